// File: rtl/dcache_direct_if.sv
// Datapath and memory-controller signals of the direct-mapped data cache.
// slave is the cache side; master drives requests and serves memory.
interface dcache_direct_if;
  logic        halt;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        dhit;
  logic [31:0] dmemload;
  logic        flushed;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;

  modport slave (
    input  halt, dmemREN, dmemWEN,
    input  dmemaddr, dmemstore,
    output dhit, dmemload, flushed,
    output dREN, dWEN, daddr, dstore,
    input  dwait, dload
  );

  modport master (
    output halt, dmemREN, dmemWEN,
    output dmemaddr, dmemstore,
    input  dhit, dmemload, flushed,
    input  dREN, dWEN, daddr, dstore,
    output dwait, dload
  );
endinterface

// File: rtl/dcache_direct.sv
// Direct-mapped write-back write-allocate data cache, two-word blocks.
// Misses evict/fill over the memory port; halt flushes all dirty blocks.
module dcache_direct #(
  parameter int SETS = 8
) (
  input logic       CLK,
  input logic       nRST,
  dcache_direct_if.slave bus
);
  localparam int IDX = $clog2(SETS);
  localparam int TW  = 29 - IDX;

  typedef enum logic [3:0] {
    S_IDLE, S_WB0, S_WB1, S_LD0, S_LD1,
    S_FL_CHK, S_FL_WB0, S_FL_WB1, S_FL_DONE
  } state_t;

  state_t          r_state, w_nxt;
  logic [SETS-1:0] r_valid, r_dirty;
  logic [IDX-1:0]  r_fidx;
  logic [TW-1:0]   r_tag [SETS];
  logic [31:0]     r_w0  [SETS];
  logic [31:0]     r_w1  [SETS];
  logic [31:0]     r_ld0;

  logic [IDX-1:0]  w_idx, w_aidx;
  logic [TW-1:0]   w_tag, w_atag;
  logic            w_sel, w_req, w_hit, w_miss;
  logic            w_fl, w_last;
  logic            w_ld0, w_fill, w_wbdone, w_finc;
  logic [31:0]     w_word;
  logic [1:0]      w_unused;

  assign w_unused = bus.dmemaddr[1:0];
  assign w_idx    = bus.dmemaddr[2+IDX:3];
  assign w_tag    = bus.dmemaddr[31:3+IDX];
  assign w_sel    = bus.dmemaddr[2];
  assign w_req    = bus.dmemREN | bus.dmemWEN;
  assign w_word   = w_sel ? r_w1[w_idx] : r_w0[w_idx];

  assign w_hit = (r_state == S_IDLE) & ~bus.halt & w_req
               & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
  assign w_miss = ~bus.halt & w_req & ~w_hit;

  assign bus.dhit     = w_hit;
  assign bus.dmemload = w_hit ? w_word : '0;

  // Write-back states are shared by miss eviction and flush.
  assign w_fl   = (r_state == S_FL_WB0) | (r_state == S_FL_WB1);
  assign w_aidx = w_fl ? r_fidx : w_idx;
  assign w_atag = r_tag[w_aidx];
  assign w_last = (r_fidx == IDX'(SETS - 1));

  always_comb begin
    w_nxt       = r_state;
    bus.dREN    = 1'b0;
    bus.dWEN    = 1'b0;
    bus.daddr   = '0;
    bus.dstore  = '0;
    bus.flushed = 1'b0;
    w_ld0       = 1'b0;
    w_fill      = 1'b0;
    w_wbdone    = 1'b0;
    w_finc      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        unique case (1'b1)
          bus.halt: w_nxt = S_FL_CHK;
          w_miss: begin
            if (r_valid[w_idx] & r_dirty[w_idx])
              w_nxt = S_WB0;
            else
              w_nxt = S_LD0;
          end
          default: ;
        endcase
      end
      S_WB0, S_FL_WB0: begin
        bus.dWEN   = 1'b1;
        bus.daddr  = {w_atag, w_aidx, 3'b000};
        bus.dstore = r_w0[w_aidx];
        if (!bus.dwait)
          w_nxt = (r_state == S_WB0) ? S_WB1 : S_FL_WB1;
      end
      S_WB1, S_FL_WB1: begin
        bus.dWEN   = 1'b1;
        bus.daddr  = {w_atag, w_aidx, 3'b100};
        bus.dstore = r_w1[w_aidx];
        if (!bus.dwait) begin
          if (r_state == S_WB1) begin
            w_nxt = S_LD0;
          end else begin
            w_wbdone = 1'b1;
            w_finc   = ~w_last;
            w_nxt    = w_last ? S_FL_DONE : S_FL_CHK;
          end
        end
      end
      S_LD0: begin
        bus.dREN  = 1'b1;
        bus.daddr = {w_tag, w_idx, 3'b000};
        if (!bus.dwait) begin
          w_ld0 = 1'b1;
          w_nxt = S_LD1;
        end
      end
      S_LD1: begin
        bus.dREN  = 1'b1;
        bus.daddr = {w_tag, w_idx, 3'b100};
        if (!bus.dwait) begin
          w_fill = 1'b1;
          w_nxt  = S_IDLE;
        end
      end
      S_FL_CHK: begin
        if (r_valid[r_fidx] & r_dirty[r_fidx])
          w_nxt = S_FL_WB0;
        else if (w_last)
          w_nxt = S_FL_DONE;
        else
          w_finc = 1'b1;
      end
      S_FL_DONE: bus.flushed = 1'b1;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= S_IDLE;
      r_valid <= '0;
      r_dirty <= '0;
      r_fidx  <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_hit & bus.dmemWEN)
        r_dirty[w_idx] <= 1'b1;
      if (w_fill) begin
        r_valid[w_idx] <= 1'b1;
        r_dirty[w_idx] <= 1'b0;
      end
      if (w_wbdone)
        r_dirty[r_fidx] <= 1'b0;
      if (w_finc)
        r_fidx <= r_fidx + 1'b1;
    end
  end

  // Word0 is staged so an aborted fill never touches the frame.
  always_ff @(posedge CLK) begin
    if (w_ld0)
      r_ld0 <= bus.dload;
    if (w_hit & bus.dmemWEN) begin
      if (w_sel)
        r_w1[w_idx] <= bus.dmemstore;
      else
        r_w0[w_idx] <= bus.dmemstore;
    end
    if (w_fill) begin
      r_w0[w_idx]  <= r_ld0;
      r_w1[w_idx]  <= bus.dload;
      r_tag[w_idx] <= w_tag;
    end
  end
endmodule

// File: tb/tb_dcache_direct.sv
// Random and directed checks of dcache_direct against a flat-memory
// reference with a tag/dirty model of the block frames.
module tb_dcache_direct;
  logic CLK = 1'b0;
  logic nRST;

  dcache_direct_if bus();

  dcache_direct #(.SETS(8)) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  bit          rv [8];
  bit          rd [8];
  logic [25:0] rt [8];
  logic [32:0] txq [$];
  logic [32:0] exq [$];
  int          wait_mode = 0;

  assign bus.dload = mem[bus.daddr[9:2]];

  always @(posedge CLK) begin
    if (nRST === 1'b1 && (bus.dREN || bus.dWEN) && !bus.dwait) begin
      if (bus.dWEN)
        mem[bus.daddr[9:2]] <= bus.dstore;
      txq.push_back({bus.dWEN, bus.daddr});
    end
  end

  always @(posedge CLK) begin
    #3;
    if (wait_mode == 2)
      bus.dwait = 1'b1;
    else if (wait_mode == 1)
      bus.dwait = ($urandom_range(0, 2) == 0);
    else
      bus.dwait = 1'b0;
  end

  task automatic chk_zero(input string tag);
    check({tag, "_dhit"}, bus.dhit, 0);
    check({tag, "_load"}, bus.dmemload, 0);
    check({tag, "_flushed"}, bus.flushed, 0);
    check({tag, "_dREN"}, bus.dREN, 0);
    check({tag, "_dWEN"}, bus.dWEN, 0);
    check({tag, "_daddr"}, bus.daddr, 0);
    check({tag, "_dstore"}, bus.dstore, 0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    for (int i = 0; i < 8; i++) begin
      rv[i] = 0;
      rd[i] = 0;
      rt[i] = '0;
    end
  endtask

  task automatic access(input bit w, input bit both,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        input int hold);
    logic [2:0]  idx;
    logic [25:0] tg;
    logic [31:0] expd;
    bit          hit;
    int          n;
    idx = a[5:3];
    tg  = a[31:6];
    hit = rv[idx] && (rt[idx] == tg);
    exq.delete();
    if (!hit) begin
      if (rv[idx] && rd[idx]) begin
        exq.push_back({1'b1, rt[idx], idx, 3'b000});
        exq.push_back({1'b1, rt[idx], idx, 3'b100});
      end
      exq.push_back({1'b0, tg, idx, 3'b000});
      exq.push_back({1'b0, tg, idx, 3'b100});
      rv[idx] = 1;
      rt[idx] = tg;
      rd[idx] = 0;
    end
    expd = ref_mem[a[9:2]];
    if (w) begin
      rd[idx] = 1;
      ref_mem[a[9:2]] = d;
    end
    txq.delete();
    @(posedge CLK);
    #1;
    bus.dmemREN   = !w || both;
    bus.dmemWEN   = w;
    bus.dmemaddr  = a;
    bus.dmemstore = d;
    if (hold > 0) begin
      wait_mode = 2;
      repeat (hold) begin
        @(posedge CLK);
        @(negedge CLK);
        check("hold_dREN", bus.dREN, 1);
        check("hold_daddr", bus.daddr, {a[31:3], 3'b000});
        check("hold_ntx", txq.size(), 0);
      end
      wait_mode = 0;
    end
    n = 0;
    @(negedge CLK);
    while (!bus.dhit && n < 400) begin
      @(negedge CLK);
      n++;
    end
    check("dhit", bus.dhit, 1);
    check("zero_latency", (n == 0), hit);
    check("bus_quiet", {bus.dREN, bus.dWEN}, 0);
    if (!w)
      check("load", bus.dmemload, expd);
    check("ntx", txq.size(), exq.size());
    foreach (exq[i])
      if (i < txq.size())
        check("tx", txq[i], exq[i]);
    @(posedge CLK);
    #1;
    bus.dmemREN = 0;
    bus.dmemWEN = 0;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] ra;
    bit          w;
    bit          both;
    int          n;
    int          nh;
    int          bad;

    nRST          = 0;
    bus.halt      = 0;
    bus.dmemREN   = 0;
    bus.dmemWEN   = 0;
    bus.dmemaddr  = '0;
    bus.dmemstore = '0;
    bus.dwait     = 0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    model_reset();
    #1;
    chk_zero("reset");
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    nRST = 1;

    access(0, 0, 32'h40, 0, 0);
    access(1, 0, 32'h44, 32'hDEADBEEF, 0);
    access(0, 0, 32'h44, 0, 0);
    access(0, 0, 32'h84, 0, 0);
    check("wb_data", mem[17], 32'hDEADBEEF);
    access(0, 0, 32'h108, 0, 5);

    wait_mode = 1;
    repeat (300) begin
      a    = $urandom_range(0, 255) << 2;
      w    = $urandom_range(0, 1);
      both = w && ($urandom_range(0, 7) == 0);
      access(w, both, a, $urandom, 0);
    end

    wait_mode = 0;
    ra = (rv[2] && rt[2] == 26'd7) ? 32'h3D0 : 32'h1D0;
    @(posedge CLK);
    #1;
    bus.dmemREN  = 1;
    bus.dmemaddr = ra;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!(bus.dREN && bus.daddr == (ra | 32'h4)) && n < 50);
    check("ld1_seen", (bus.dREN && bus.daddr == (ra | 32'h4)), 1);
    #1;
    nRST = 0;
    #1;
    chk_zero("reset_mid");
    bus.dmemREN = 0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    nRST = 1;
    model_reset();
    access(0, 0, ra, 0, 0);

    wait_mode = 1;
    access(1, 0, 32'h000, $urandom, 0);
    access(1, 0, 32'h118, $urandom, 0);
    access(0, 0, 32'h128, 0, 0);
    exq.delete();
    for (int s = 0; s < 8; s++) begin
      if (rv[s] && rd[s]) begin
        exq.push_back({1'b1, rt[s], 3'(s), 3'b000});
        exq.push_back({1'b1, rt[s], 3'(s), 3'b100});
      end
    end
    txq.delete();
    @(posedge CLK);
    #1;
    bus.halt     = 1;
    bus.dmemREN  = 1;
    bus.dmemaddr = 32'h000;
    n  = 0;
    nh = 0;
    @(negedge CLK);
    while (!bus.flushed && n < 300) begin
      if (bus.dhit) nh++;
      @(negedge CLK);
      n++;
    end
    check("flushed", bus.flushed, 1);
    check("flush_dhit", nh, 0);
    check("flush_ntx", txq.size(), exq.size());
    foreach (exq[i])
      if (i < txq.size())
        check("flush_tx", txq[i], exq[i]);
    bad = 0;
    repeat (10) begin
      @(negedge CLK);
      if (!bus.flushed || bus.dhit || bus.dREN || bus.dWEN) bad++;
    end
    check("flush_hold", bad, 0);
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== ref_mem[i]) bad++;
    check("mem_coherent", bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
